// File: rtl/fft8_pkg.sv
// Shared types and helpers for the iterative 8-point DIT FFT.
// FFT_STAGE_SCALE_EN: halve every butterfly result, so outputs keep the input width.
package fft8_pkg;

  localparam int unsigned DW_DEF = 16;
  localparam int unsigned TW_DEF = 10;

`ifdef FFT_STAGE_SCALE_EN
  localparam int unsigned OW_GROWTH = 0;
  localparam int unsigned STAGE_SHIFT = 1;
`else
  localparam int unsigned OW_GROWTH = 3;
  localparam int unsigned STAGE_SHIFT = 0;
`endif

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

  typedef struct packed {
    logic [2:0] top;
    logic [2:0] bot;
    logic [1:0] k;
  } bfly_idx_t;

  function automatic logic [2:0] bitrev3(logic [2:0] n);
    return {n[0], n[1], n[2]};
  endfunction

  // step = {stage, butterfly}; top/bot memory slots and twiddle exponent
  function automatic bfly_idx_t bfly_idx(logic [3:0] step);
    bfly_idx_t r;
    logic [1:0] b;
    b = step[1:0];
    case (step[3:2])
      2'd0: begin
        r.top = {b, 1'b0};
        r.bot = r.top + 3'd1;
        r.k   = 2'd0;
      end
      2'd1: begin
        r.top = {b[1], 1'b0, b[0]};
        r.bot = r.top + 3'd2;
        r.k   = {b[0], 1'b0};
      end
      default: begin
        r.top = {1'b0, b};
        r.bot = r.top + 3'd4;
        r.k   = b;
      end
    endcase
    return r;
  endfunction

  // W8^k = cos(pi*k/4) - j*sin(pi*k/4) with tw-2 fractional bits; im selects the imaginary part
  function automatic logic signed [31:0] tw_val(int unsigned tw, logic [1:0] k, logic im);
    longint one;
    longint r2;
    longint v;
    one = longint'(1) << (tw - 2);
    r2  = (one * 46341 + 32768) >>> 16;
    if (!im) begin
      case (k)
        2'd0:    v = one;
        2'd1:    v = r2;
        2'd2:    v = 0;
        default: v = -r2;
      endcase
    end else begin
      case (k)
        2'd0:    v = 0;
        2'd1:    v = -r2;
        2'd2:    v = -one;
        default: v = -r2;
      endcase
    end
    return 32'(v);
  endfunction

endpackage

// File: rtl/dit_fft8_seq_if.sv
// Sample-in / bin-out streaming bus of the sequential 8-point FFT.
interface dit_fft8_seq_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned OW = 19
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_re;
  logic signed [DW-1:0] in_im;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_re;
  logic signed [OW-1:0] out_im;
  logic [2:0]           out_idx;
  logic                 out_last;

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_idx, out_last
  );
endinterface

// File: rtl/fft8_bfly.sv
// Combinational radix-2 butterfly: sum = a + w*b, diff = a - w*b, {re, im} packed.
// FFT_STAGE_SCALE_EN: both results are halved (round-half-up) before leaving.
module fft8_bfly
  import fft8_pkg::*;
#(
  parameter int unsigned W  = 19,
  parameter int unsigned TW = 10
) (
  input  logic [2*W-1:0]  a,
  input  logic [2*W-1:0]  b,
  input  logic [2*TW-1:0] w,
  output logic [2*W-1:0]  sum,
  output logic [2*W-1:0]  diff
);
  localparam int unsigned PW = W + TW + 2;
  localparam logic signed [PW-1:0] RND = PW'(1) << (TW - 3);
  localparam logic signed [PW-1:0] SRND = PW'(STAGE_SHIFT);

  logic signed [PW-1:0] ar, ai, br, bi, wr, wi;
  logic signed [PW-1:0] pr, pi, tr, ti, sr, si, dr, di;

  always_comb begin
    ar = PW'($signed(a[2*W-1:W]));
    ai = PW'($signed(a[W-1:0]));
    br = PW'($signed(b[2*W-1:W]));
    bi = PW'($signed(b[W-1:0]));
    wr = PW'($signed(w[2*TW-1:TW]));
    wi = PW'($signed(w[TW-1:0]));
    // full-precision product, round-half-up back to sample scale
    pr = br * wr - bi * wi;
    pi = br * wi + bi * wr;
    tr = (pr + RND) >>> (TW - 2);
    ti = (pi + RND) >>> (TW - 2);
    sr = ar + tr;
    si = ai + ti;
    dr = ar - tr;
    di = ai - ti;
    sum  = {W'((sr + SRND) >>> STAGE_SHIFT), W'((si + SRND) >>> STAGE_SHIFT)};
    diff = {W'((dr + SRND) >>> STAGE_SHIFT), W'((di + SRND) >>> STAGE_SHIFT)};
  end
endmodule

// File: rtl/dit_fft8_seq.sv
// Iterative 8-point radix-2 DIT FFT: load 8 samples, 12 shared-butterfly steps, stream X[0..7].
// FFT_STAGE_SCALE_EN: per-stage halving, OW = DW and outputs are DFT/8.
module dit_fft8_seq
  import fft8_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned TW = TW_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  dit_fft8_seq_if.slave bus
);
  localparam int unsigned OW = DW + OW_GROWTH;

  state_t               state, state_nxt;
  logic [2:0]           cnt;
  logic [3:0]           step;
  logic [2*OW-1:0]      mem [8];
  bfly_idx_t            ix;
  logic [2*TW-1:0]      w;
  logic [2*OW-1:0]      bf_sum, bf_diff;
  logic                 in_ready_q, out_valid_q, out_last_q;
  logic signed [OW-1:0] out_re_q, out_im_q;
  logic [2:0]           out_idx_q, idx_nxt;
  logic                 in_fire, out_fire, last_step;

  assign in_fire   = bus.in_valid && in_ready_q;
  assign out_fire  = out_valid_q && bus.out_ready;
  // step 12 performs no butterfly; it preloads bin 0 into the output register
  assign last_step = (step == 4'd12);
  assign idx_nxt   = out_idx_q + 3'd1;
  assign ix        = bfly_idx(step);
  assign w         = {TW'(tw_val(TW, ix.k, 1'b0)), TW'(tw_val(TW, ix.k, 1'b1))};

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_re    = out_re_q;
  assign bus.out_im    = out_im_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;

  fft8_bfly #(.W(OW), .TW(TW)) u_bfly (
    .a    (mem[ix.top]),
    .b    (mem[ix.bot]),
    .w    (w),
    .sum  (bf_sum),
    .diff (bf_diff)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (in_fire && cnt == 3'd7) state_nxt = COMPUTE;
      COMPUTE: if (last_step) state_nxt = UNLOAD;
      UNLOAD:  if (out_fire && out_idx_q == 3'd7) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // sample memory: bit-reversed load, in-place butterfly write-back
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem[bitrev3(cnt)] <= {OW'(bus.in_re), OW'(bus.in_im)};
    end else if (state == COMPUTE && !last_step) begin
      mem[ix.top] <= bf_sum;
      mem[ix.bot] <= bf_diff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= 3'd0;
      step        <= 4'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_idx_q   <= 3'd0;
      out_last_q  <= 1'b0;
    end else begin
      in_ready_q <= (state_nxt == LOAD);
      case (state)
        LOAD: if (in_fire) cnt <= cnt + 3'd1;
        COMPUTE: begin
          step <= last_step ? 4'd0 : step + 4'd1;
          if (last_step) begin
            out_valid_q            <= 1'b1;
            {out_re_q, out_im_q}   <= mem[0];
            out_idx_q              <= 3'd0;
            out_last_q             <= 1'b0;
          end
        end
        UNLOAD: if (out_fire) begin
          if (out_idx_q == 3'd7) begin
            out_valid_q <= 1'b0;
            out_idx_q   <= 3'd0;
            out_last_q  <= 1'b0;
          end else begin
            out_idx_q            <= idx_nxt;
            {out_re_q, out_im_q} <= mem[idx_nxt];
            out_last_q           <= (idx_nxt == 3'd7);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
